// File: rtl/pattern_detector_pkg.sv
// Shared types and constants for the serial pattern detector.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package pattern_detector_pkg;

    // Control FSM states: IDLE until the first pattern load, FILL while the
    // history window is still short, ARMED once the window is full.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        ARMED = 2'd2
    } state_t;

    // Overlap mode select values as latched on pat_load.
    localparam logic OVL_ON  = 1'b1;
    localparam logic OVL_OFF = 1'b0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear+inc together yields 1.
// Latency: count reflects inc/clr one clock after they are sampled.
// Backpressure: none; inc is counted every cycle it is high until saturation.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    // Count up on inc, hold at all-ones instead of wrapping, clear on clr.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= inc ? W'(1) : '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/pattern_detector.sv
// Serial pattern detector: matches the last PAT_W accepted bits against a loaded pattern.
// Latency: y pulses one clock after the accepted bit that completes a match.
// Backpressure: none; a bit is consumed on every cycle en=1, en=0 simply holds state.
module pattern_detector
    import pattern_detector_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             w,
    input  logic             en,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    input  logic             cnt_clr,
    output logic             y,
    output logic [CNT_W-1:0] match_cnt
);

    // fill runs 0..PAT_W inclusive, so it needs one more code than PAT_W.
    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
    localparam logic [FILL_W:0]   FILL_TGT = (FILL_W + 1)'(PAT_W);

    state_t              state;
    logic [PAT_W-1:0]    hist;
    logic [PAT_W-1:0]    pat_q;
    logic                ovl_q;
    logic [FILL_W-1:0]   fill;

    logic                accept;
    logic                match;
    logic [PAT_W-1:0]    window;
    logic [FILL_W:0]     fill_inc;
    logic [FILL_W-1:0]   fill_nxt;

    // Candidate window, match decision and next fill level for the current bit.
    always_comb begin
        window   = {hist[PAT_W-2:0], w};
        // A load cycle swallows w; IDLE ignores bits until a pattern is loaded.
        accept   = en && !pat_load && (state != IDLE);
        // Extra MSB keeps fill+1 from wrapping when fill is already PAT_W.
        fill_inc = {1'b0, fill} + (FILL_W + 1)'(1);
        match    = accept && (fill_inc >= FILL_TGT) && (window == pat_q);
        fill_nxt = fill;
        if (match && (ovl_q == OVL_OFF)) begin
            // Non-overlap: the next match must be built from entirely fresh bits.
            fill_nxt = '0;
        end else if (fill_inc > FILL_TGT) begin
            fill_nxt = FILL_MAX;
        end else begin
            fill_nxt = fill_inc[FILL_W-1:0];
        end
    end

    // Control FSM with history, fill level, latched pattern/mode and registered match pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            fill  <= '0;
            hist  <= '0;
            y     <= 1'b0;
            pat_q <= '1;
            ovl_q <= OVL_ON;
        end else begin
            y <= 1'b0;
            if (pat_load) begin
                pat_q <= pattern;
                ovl_q <= overlap;
                hist  <= '0;
                fill  <= '0;
                state <= FILL;
            end else if (accept) begin
                hist  <= window;
                fill  <= fill_nxt;
                y     <= match;
                state <= (fill_nxt == FILL_MAX) ? ARMED : FILL;
            end
        end
    end

    // Match counter is independent of pattern loads; only reset and cnt_clr clear it.
    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (match),
        .clr   (cnt_clr),
        .cnt   (match_cnt)
    );

endmodule

// File: tb/tb_pattern_detector.sv
// Directed bench for pattern_detector with a queue-based reference model.
// Two instances share stimulus: one with an 8-bit counter, one with a 2-bit counter.
module tb_pattern_detector;

    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          w = 1'b0;
    logic          en = 1'b0;
    logic          pat_load = 1'b0;
    logic [PW-1:0] pattern = '0;
    logic          overlap = 1'b0;
    logic          cnt_clr = 1'b0;
    logic          y_a, y_b;
    logic [7:0]    cnt_a;
    logic [1:0]    cnt_b;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_on  = 1'b0;

    pattern_detector #(.PAT_W(PW), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .w(w), .en(en), .pat_load(pat_load),
        .pattern(pattern), .overlap(overlap), .y(y_a), .match_cnt(cnt_a),
        .cnt_clr(cnt_clr)
    );

    pattern_detector #(.PAT_W(PW), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .w(w), .en(en), .pat_load(pat_load),
        .pattern(pattern), .overlap(overlap), .y(y_b), .match_cnt(cnt_b),
        .cnt_clr(cnt_clr)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endfunction

    // Reference model: a queue of the bits that count toward the next match window.
    int            m_q[$];
    bit            m_loaded = 0;
    logic [PW-1:0] m_pat = '1;
    bit            m_ovl = 1;
    bit            m_y = 0;
    int            m_cnt_a = 0;
    int            m_cnt_b = 0;

    always @(posedge clk or posedge reset) begin
        bit hit;
        int v;
        hit = 0;
        if (reset) begin
            m_loaded = 0; m_pat = '1; m_ovl = 1; m_q.delete();
            m_y = 0; m_cnt_a = 0; m_cnt_b = 0;
        end else begin
            if (pat_load) begin
                m_pat = pattern; m_ovl = overlap; m_q.delete(); m_loaded = 1;
            end else if (en && m_loaded) begin
                m_q.push_back(int'(w));
                if (m_q.size() > PW) void'(m_q.pop_front());
                if (m_q.size() == PW) begin
                    v = 0;
                    foreach (m_q[i]) v = v * 2 + m_q[i];
                    hit = (v == int'(m_pat));
                end
                if (hit && !m_ovl) m_q.delete();
            end
            m_y = hit;
            if (cnt_clr) begin
                m_cnt_a = hit ? 1 : 0;
                m_cnt_b = hit ? 1 : 0;
            end else if (hit) begin
                m_cnt_a = (m_cnt_a < 255) ? m_cnt_a + 1 : 255;
                m_cnt_b = (m_cnt_b < 3) ? m_cnt_b + 1 : 3;
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            check("model_y_a", int'(y_a), int'(m_y));
            check("model_y_b", int'(y_b), int'(m_y));
            check("model_cnt_a", int'(cnt_a), m_cnt_a);
            check("model_cnt_b", int'(cnt_b), m_cnt_b);
        end
    end

    // One clock of stimulus, applied at a falling edge; returns y seen after the rising edge.
    task automatic cyc(input logic e, input logic b, input logic ld, input logic clr,
                       output logic yo);
        en = e; w = b; pat_load = ld; cnt_clr = clr;
        @(negedge clk);
        yo = y_a;
        en = 1'b0; pat_load = 1'b0; cnt_clr = 1'b0;
    endtask

    // Load pattern/mode; en=1 with w=1 shows w is ignored on a load cycle.
    task automatic load(input logic [PW-1:0] p, input logic ov);
        logic yd;
        pattern = p; overlap = ov;
        cyc(1'b1, 1'b1, 1'b1, 1'b0, yd);
    endtask

    task automatic clear_cnt();
        logic yd;
        cyc(1'b0, 1'b0, 1'b0, 1'b1, yd);
    endtask

    // Send n bits MSB-first with 'gap' en=0 cycles after each; collect y per bit and any y in gaps.
    task automatic send(input logic [15:0] bits, input int n, input int gap,
                        output logic [15:0] ys, output logic gap_y);
        logic yo;
        ys = '0; gap_y = 1'b0;
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, bits[n-1-i], 1'b0, 1'b0, yo);
            ys[n-1-i] = yo;
            for (int g = 0; g < gap; g++) begin
                cyc(1'b0, 1'b1, 1'b0, 1'b0, yo);
                gap_y = gap_y | yo;
            end
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] ys;
        logic        gy;
        logic        yo;

        #1 reset = 1'b1;
        @(negedge clk);
        check("reset_y", int'(y_a), 0);
        check("reset_cnt_a", int'(cnt_a), 0);
        check("reset_cnt_b", int'(cnt_b), 0);
        reset = 1'b0;
        chk_on = 1'b1;

        // IDLE: bits matching the reset-default pattern are still ignored.
        send(16'b1111, 4, 0, ys, gy);
        check("idle_ignored_y", int'(ys), 0);
        check("idle_cnt", int'(cnt_a), 0);

        // Overlap, 1111, six ones.
        load(4'b1111, 1'b1);
        send(16'b111111, 6, 0, ys, gy);
        check("ovl_y_pattern", int'(ys), 'b000111);
        check("ovl_cnt", int'(cnt_a), 3);

        // Non-overlap, six ones then eight ones.
        clear_cnt();
        check("clr_cnt", int'(cnt_a), 0);
        load(4'b1111, 1'b0);
        send(16'b111111, 6, 0, ys, gy);
        check("novl6_y_pattern", int'(ys), 'b000100);
        check("novl6_cnt", int'(cnt_a), 1);
        clear_cnt();
        load(4'b1111, 1'b0);
        send(16'hFF, 8, 0, ys, gy);
        check("novl8_y_pattern", int'(ys), 'b00010001);
        check("novl8_cnt", int'(cnt_a), 2);

        // Gaps: 1011 overlap, bits 1,0,1,1,0,1,1 with an en=0 cycle after each.
        clear_cnt();
        load(4'b1011, 1'b1);
        send(16'b1011011, 7, 1, ys, gy);
        check("gap_y_pattern", int'(ys), 'b0001001);
        check("gap_no_y_in_gaps", int'(gy), 0);
        check("gap_cnt", int'(cnt_a), 2);

        // Reset mid-sequence discards partial history.
        load(4'b1111, 1'b1);
        send(16'b111, 3, 0, ys, gy);
        #2 reset = 1'b1;
        #6 reset = 1'b0;
        @(negedge clk);
        check("midrst_cnt", int'(cnt_a), 0);
        load(4'b1111, 1'b1);
        send(16'b1, 1, 0, ys, gy);
        check("midrst_first_bit_y", int'(ys), 0);
        send(16'b111, 3, 0, ys, gy);
        check("midrst_y_pattern", int'(ys), 'b001);
        check("midrst_cnt_after", int'(cnt_a), 1);

        // Saturation of the 2-bit counter, then clear coinciding with a match.
        clear_cnt();
        load(4'b1111, 1'b1);
        send(16'hFF, 8, 0, ys, gy);
        check("sat_y_pattern", int'(ys), 'b00011111);
        check("sat_cnt_b", int'(cnt_b), 3);
        check("sat_cnt_a", int'(cnt_a), 5);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, yo);
        check("clr_match_y", int'(yo), 1);
        check("clr_match_cnt_a", int'(cnt_a), 1);
        check("clr_match_cnt_b", int'(cnt_b), 1);

        // Reload after three bits that would otherwise complete 0011.
        load(4'b1011, 1'b1);
        send(16'b001, 3, 0, ys, gy);
        load(4'b0011, 1'b1);
        check("reload_keeps_cnt", int'(cnt_a), 1);
        send(16'b10011, 5, 0, ys, gy);
        check("reload_y_pattern", int'(ys), 'b00001);

        // Changing pattern without a load has no effect.
        pattern = 4'b1111;
        overlap = 1'b0;
        send(16'b0011, 4, 0, ys, gy);
        check("noload_y_pattern", int'(ys), 'b0001);
        send(16'b1111, 4, 0, ys, gy);
        check("noload_1111_ignored", int'(ys), 0);

        repeat (2) @(negedge clk);
        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pattern_detector.md
PATTERN_DETECTOR -- requirements
Module: pattern_detector

Interface
REQ-001 Parameter PAT_W, default 4: pattern length in bits; legal range 2..16.
REQ-002 Parameter CNT_W, default 8: width of the match counter; legal range 2..16.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 w  input  1  serial data bit.
REQ-006 en  input  1  bit-valid qualifier; w is sampled only when en=1.
REQ-007 pat_load  input  1  when 1, latch pattern and mode, and clear the history.
REQ-008 pattern  input  PAT_W  target sequence; MSB is the first-received bit.
REQ-009 overlap  input  1  mode select, latched on pat_load: 1 = overlapping, 0 = non-overlapping.
REQ-010 y  output  1  one-cycle registered match pulse.
REQ-011 match_cnt  output  CNT_W  saturating count of matches.
REQ-012 cnt_clr  input  1  synchronous clear of match_cnt.

Function
REQ-013 The block shall hold a history shift register hist[PAT_W-1:0] and a fill counter fill, range 0..PAT_W.
REQ-014 On an accepted bit (en=1, pat_load=0), hist shall take {hist[PAT_W-2:0], w}, and fill shall increment, saturating at PAT_W.
REQ-015 A match shall occur on an accepted bit when two conditions hold: (fill+1) >= PAT_W, and {hist[PAT_W-2:0], w} equals the latched pattern.
REQ-016 y shall be 1 in the cycle after the accepted bit that completes a match, and 0 otherwise; latency is 1 clock.
REQ-017 In overlap mode, fill shall stay at PAT_W after a match, so a window sharing bits with the previous match can match again.
REQ-018 In non-overlap mode, fill shall reset to 0 on a match, so the next match needs PAT_W fresh bits.
REQ-019 When en=0, hist, fill and y shall behave as follows: hist and fill hold; y=0.
REQ-020 On pat_load=1, the block shall latch pattern and overlap, clear fill to 0, and drive y=0 next cycle; w shall be ignored that cycle, whatever en is.
REQ-021 On a match, match_cnt shall increment by 1 and saturate at 2^CNT_W-1 without wrapping.
REQ-022 If cnt_clr=1 and a match occur in the same cycle, match_cnt shall become 1.
REQ-023 match_cnt shall be unaffected by pat_load.
REQ-024 Pattern or overlap changes shall have no effect without pat_load.
REQ-025 The control path shall be a three-state FSM:
- IDLE: after reset, before the first pat_load.
- FILL: fill < PAT_W.
- ARMED: fill == PAT_W.
REQ-026 FSM transitions shall be:
- IDLE to FILL on pat_load.
- FILL to ARMED when fill reaches PAT_W.
- ARMED to FILL on a non-overlap match.
- Any state to FILL on pat_load.
REQ-027 In IDLE, accepted bits shall be ignored and y shall stay 0.

Reset
REQ-028 Asserting reset shall immediately set the following, regardless of clk:
- state = IDLE, fill = 0, hist = 0, y = 0, match_cnt = 0.
- latched pattern = all ones, latched overlap = 1.
REQ-029 Reset asserted mid-sequence shall discard partial history; no match shall be reported for bits received before deassertion.
REQ-030 After deassertion, the block shall stay in IDLE until pat_load.

Structure
REQ-031 State encodings (IDLE, FILL, ARMED) and the mode constants OVL_ON/OVL_OFF shall live in the shared package pattern_detector_pkg.
REQ-032 The saturating counter with synchronous clear shall be the sub-module sat_counter, parameterised by width.
REQ-033 The FSM, history register and compare logic shall stay in pattern_detector.

Verification
REQ-034 Overlap: PAT_W=4, load 1111 with overlap=1, then 6 accepted ones -> y pulses after bits 4, 5 and 6; match_cnt = 3.
REQ-035 Non-overlap: same stimulus with overlap=0 -> y pulses after bit 4 only; match_cnt = 1; an 8-ones stream gives match_cnt = 2.
REQ-036 Gaps and pattern: load 1011, overlap=1, send bits 1,0,1,1,0,1,1 with en=0 cycles inserted between them -> y pulses after bit 4 and after bit 7; no y during en=0 cycles.
REQ-037 Reset mid-sequence: after 3 ones, pulse reset, pat_load 1111, then 1 more one -> y stays 0; 3 further ones -> y pulses once.
REQ-038 Saturation and clear: CNT_W=2, 5 matches -> match_cnt = 3; cnt_clr together with a match -> match_cnt = 1.
REQ-039 Reload: pat_load with new pattern 0011 after 3 matching bits -> history cleared; a match needs 4 new bits.
